cavlc_coeff_expander: RTL and testbench
=======================================

// Module: cavlc_coeff_expander
// PURPOSE
//  Decoder-side counterpart of the CAVLC total-coefficient counting stage.
//  Rebuilds one residual block from header values and (level, run_before) pairs:
//   - header: TotalCoeff, TotalZeros.
//   - pairs: arrive from the level/run_before parser, in reverse zigzag order.
//  The block is then streamed out in zigzag order, index 0 first, to inverse
//  quant/transform over a valid/ready handshake.
// PARAMETERS
//  COEFF_W    8   signed coefficient/level width (two's complement)
//  MAX_COEFF  16  coefficients per block (16 luma 4x4, 15 AC, 4 chroma DC)
//  IDX_W      $clog2(MAX_COEFF)  index/run width (derived, not overridden)
// PORTS
//  clk            in   1              clock, rising edge
//  rst            in   1              async reset, active-low
//  blk_start_i    in   1              pulse: latch header, clear buffer (IDLE only)
//  total_coeff_i  in   IDX_W+1        TotalCoeff, 0..MAX_COEFF
//  total_zeros_i  in   IDX_W          TotalZeros, 0..MAX_COEFF-1
//  pair_valid_i   in   1              level/run pair valid
//  pair_ready_o   out  1              pair accepted when valid&ready
//  level_i        in   COEFF_W        nonzero level (signed)
//  run_before_i   in   IDX_W          zeros preceding this level in scan order
//  coeff_valid_o  out  1              output coefficient valid
//  coeff_ready_i  in   1              downstream ready
//  coeff_o        out  COEFF_W        coefficient value
//  coeff_idx_o    out  IDX_W          zigzag index of coeff_o
//  blk_done_o     out  1              1-cycle pulse after last output handshake
//  busy_o         out  1              high in any state except IDLE
//  err_o          out  1              sticky bitstream error, cleared by blk_start_i
// BEHAVIOUR
//  Reset (rst=0, async):
//   - State goes to IDLE; all buffer entries, pos, zeros_left and cnt are 0.
//   - All outputs are 0.
//  FSM states: IDLE -> FILL -> EMIT -> IDLE.
//  IDLE:
//   - blk_start_i latches tc=total_coeff_i, zl=total_zeros_i.
//   - Clears all MAX_COEFF buffer entries in the same cycle.
//   - Sets pos = tc+zl-1 and cnt=0.
//   - Next state is FILL if tc!=0, otherwise EMIT.
//  blk_start_i outside IDLE is ignored.
//  FILL:
//   - pair_ready_o=1 combinationally; one pair is consumed per handshake cycle.
//   - Accepted pair: buf[pos] <= level_i; cnt++.
//   - Pair that is not the last (cnt+1<tc): zl -= run_before_i; pos -= 1+run_before_i.
//   - Last pair (cnt+1==tc): run_before_i is ignored; the remaining zl zeros
//     sit implicitly at the indices below it. Next state is EMIT.
//  EMIT:
//   - coeff_valid_o=1; coeff_idx_o=oidx (starts at 0); coeff_o=buf[oidx].
//   - On handshake, oidx++.
//   - If coeff_valid_o=1 and coeff_ready_i=0, coeff_o and coeff_idx_o hold stable.
//   - The handshake at oidx==MAX_COEFF-1 goes to IDLE; blk_done_o pulses the next cycle.
//  Latency:
//   - blk_start to first pair_ready: 1 cycle.
//   - Last pair accepted to first coeff_valid: 1 cycle.
//   - Full-throughput block: tc + MAX_COEFF + 2 cycles.
//  Errors (err_o set the cycle after detection; processing continues):
//   - At blk_start: tc>MAX_COEFF or tc+zl>MAX_COEFF. Then pos is clamped to
//     MAX_COEFF-1 and tc is clamped to MAX_COEFF.
//   - In FILL: run_before_i>zl on a non-last pair. Then zl saturates at 0 and
//     pos decrements by 1+zl_old.
//   - In FILL: pos underflow (pos would go below 0). Further writes are
//     dropped, but pairs are still consumed until cnt==tc.
//  Arithmetic: pos/zl are unsigned IDX_W+1 bits; levels are stored unmodified
//  (no sign extension or saturation).
//  Simultaneous events: async reset dominates all.
// TESTING
//  1 tc=0,zl=0 -> FILL skipped; 16 zeros out, idx 0..15; blk_done_o once; err_o=0
//  2 tc=5,zl=4; pairs (1,1),(1,0),(-1,2),(-1,0),(3,x)
//    -> out 0,3,-1,0,0,-1,1,0,1,0,0,0,0,0,0,0; err_o=0
//  3 Case 2 with coeff_ready_i low 3 cycles at idx 4, pair_valid_i gapped
//    -> outputs held stable, same sequence, no loss or duplication
//  4 tc=10,zl=8 -> err_o=1 from cycle after start; block still completes with 16
//    outputs; next blk_start_i clears err_o
//  5 tc=16,zl=0; levels 16..1 -> out 1..16 in order; pair with run_before=2 at
//    zl=0 in tc=3,zl=0 block -> err_o=1
//  6 rst low mid-EMIT at idx 7 -> all outputs 0 immediately; IDLE after release;
//    the following block is correct with a cleared buffer

Source files
------------

// File: rtl/cavlc_coeff_expander.sv
// Rebuilds one CAVLC residual block from TotalCoeff/TotalZeros and reverse-order
// (level, run_before) pairs, then streams it out in zigzag order over valid/ready.
module cavlc_coeff_expander #(
    parameter int  COEFF_W   = 8,
    parameter int  MAX_COEFF = 16,
    localparam int IDX_W     = $clog2(MAX_COEFF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_start_i,
    input  logic [IDX_W:0]     total_coeff_i,
    input  logic [IDX_W-1:0]   total_zeros_i,
    input  logic               pair_valid_i,
    output logic               pair_ready_o,
    input  logic [COEFF_W-1:0] level_i,
    input  logic [IDX_W-1:0]   run_before_i,
    output logic               coeff_valid_o,
    input  logic               coeff_ready_i,
    output logic [COEFF_W-1:0] coeff_o,
    output logic [IDX_W-1:0]   coeff_idx_o,
    output logic               blk_done_o,
    output logic               busy_o,
    output logic               err_o
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                     state;
    logic signed [COEFF_W-1:0]  coef_buf [MAX_COEFF];
    logic [IDX_W:0]             pos;
    logic [IDX_W:0]             zl;
    logic [IDX_W:0]             tc;
    logic [IDX_W:0]             cnt;
    logic [IDX_W-1:0]           oidx;
    logic                       drop;

    logic [IDX_W+1:0]           hdr_sum;
    logic                       hdr_err;
    logic [IDX_W:0]             cnt_nxt;
    logic                       last_pair;
    logic                       run_err;
    logic [IDX_W+1:0]           step;
    logic                       pos_uf;
    logic [IDX_W:0]             pos_nxt;

    assign hdr_sum   = {1'b0, total_coeff_i} + {2'b00, total_zeros_i};
    assign hdr_err   = hdr_sum > (IDX_W+2)'(MAX_COEFF);
    assign cnt_nxt   = cnt + (IDX_W+1)'(1);
    assign last_pair = cnt_nxt == tc;

    // A run larger than the zeros left means a corrupt stream: consume only what is left.
    assign run_err   = {1'b0, run_before_i} > zl;
    assign step      = run_err ? ({1'b0, zl} + (IDX_W+2)'(1))
                               : ({2'b00, run_before_i} + (IDX_W+2)'(1));
    assign pos_uf    = step > {1'b0, pos};
    assign pos_nxt   = pos - step[IDX_W:0];

    assign pair_ready_o  = (state == FILL);
    assign coeff_valid_o = (state == EMIT);
    assign busy_o        = (state != IDLE);
    assign coeff_o       = (state == EMIT) ? coef_buf[oidx] : '0;
    assign coeff_idx_o   = oidx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            for (int i = 0; i < MAX_COEFF; i++) coef_buf[i] <= '0;
            pos        <= '0;
            zl         <= '0;
            tc         <= '0;
            cnt        <= '0;
            oidx       <= '0;
            drop       <= 1'b0;
            blk_done_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            blk_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_start_i) begin
                        for (int i = 0; i < MAX_COEFF; i++) coef_buf[i] <= '0;
                        tc    <= (total_coeff_i > (IDX_W+1)'(MAX_COEFF)) ?
                                 (IDX_W+1)'(MAX_COEFF) : total_coeff_i;
                        zl    <= {1'b0, total_zeros_i};
                        pos   <= hdr_err ? (IDX_W+1)'(MAX_COEFF - 1) :
                                 (IDX_W+1)'(hdr_sum - (IDX_W+2)'(1));
                        cnt   <= '0;
                        oidx  <= '0;
                        drop  <= 1'b0;
                        err_o <= hdr_err;
                        state <= (total_coeff_i != '0) ? FILL : EMIT;
                    end
                end
                FILL: begin
                    if (pair_valid_i) begin
                        if (!drop && pos < (IDX_W+1)'(MAX_COEFF))
                            coef_buf[pos[IDX_W-1:0]] <= level_i;
                        cnt <= cnt_nxt;
                        if (last_pair) begin
                            state <= EMIT;
                        end else begin
                            if (run_err) begin
                                err_o <= 1'b1;
                                zl    <= '0;
                            end else begin
                                zl    <= zl - {1'b0, run_before_i};
                            end
                            if (pos_uf) begin
                                err_o <= 1'b1;
                                drop  <= 1'b1;
                            end else begin
                                pos   <= pos_nxt;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (coeff_ready_i) begin
                        if (oidx == IDX_W'(MAX_COEFF - 1)) begin
                            oidx       <= '0;
                            state      <= IDLE;
                            blk_done_o <= 1'b1;
                        end else begin
                            oidx       <= oidx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_coeff_expander.sv
// Scoreboard bench: stimulus pushes reference-model blocks, a monitor pops and
// compares every output handshake and every block-done pulse.
module tb_cavlc_coeff_expander;

    localparam int COEFF_W   = 8;
    localparam int MAX_COEFF = 16;
    localparam int IDX_W     = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               blk_start_i = 1'b0;
    logic [IDX_W:0]     total_coeff_i = '0;
    logic [IDX_W-1:0]   total_zeros_i = '0;
    logic               pair_valid_i = 1'b0;
    logic               pair_ready_o;
    logic [COEFF_W-1:0] level_i = '0;
    logic [IDX_W-1:0]   run_before_i = '0;
    logic               coeff_valid_o;
    logic               coeff_ready_i = 1'b0;
    logic [COEFF_W-1:0] coeff_o;
    logic [IDX_W-1:0]   coeff_idx_o;
    logic               blk_done_o;
    logic               busy_o;
    logic               err_o;

    cavlc_coeff_expander #(.COEFF_W(COEFF_W), .MAX_COEFF(MAX_COEFF)) dut (
        .clk(clk), .rst(rst), .blk_start_i(blk_start_i),
        .total_coeff_i(total_coeff_i), .total_zeros_i(total_zeros_i),
        .pair_valid_i(pair_valid_i), .pair_ready_o(pair_ready_o),
        .level_i(level_i), .run_before_i(run_before_i),
        .coeff_valid_o(coeff_valid_o), .coeff_ready_i(coeff_ready_i),
        .coeff_o(coeff_o), .coeff_idx_o(coeff_idx_o),
        .blk_done_o(blk_done_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_val_q[$];
    int exp_idx_q[$];
    bit exp_err_q[$];
    int done_cnt = 0;
    int blk_d0 = 0;

    int lev_a[16];
    int run_a[16];
    int exp_blk[16];
    bit exp_err;

    bit rdy_rand = 1'b0;
    int stall_idx = -1;
    int stall_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: place each level at its scan position walking down from the
    // highest occupied index, with the header/run error rules applied.
    function automatic void model(input int tc, input int zl);
        int t, p, z, step;
        bit drop;
        for (int i = 0; i < 16; i++) exp_blk[i] = 0;
        exp_err = (tc + zl > MAX_COEFF);
        t = (tc > MAX_COEFF) ? MAX_COEFF : tc;
        p = exp_err ? MAX_COEFF - 1 : tc + zl - 1;
        z = zl;
        drop = 1'b0;
        for (int k = 0; k < t; k++) begin
            if (!drop) exp_blk[p] = lev_a[k];
            if (k + 1 < t) begin
                if (run_a[k] > z) begin
                    exp_err = 1'b1;
                    step = z + 1;
                    z = 0;
                end else begin
                    step = run_a[k] + 1;
                    z -= run_a[k];
                end
                if (p - step < 0) begin
                    exp_err = 1'b1;
                    drop = 1'b1;
                end else begin
                    p -= step;
                end
            end
        end
    endfunction

    task automatic push_expect();
        for (int i = 0; i < 16; i++) begin
            exp_val_q.push_back(exp_blk[i]);
            exp_idx_q.push_back(i);
        end
        exp_err_q.push_back(exp_err);
    endtask

    // Caller is at posedge+1 on entry and on return.
    task automatic start_block(input int tc, input int zl, input int gap_max);
        int n, t;
        blk_d0 = done_cnt;
        blk_start_i = 1'b1;
        total_coeff_i = (IDX_W+1)'(tc);
        total_zeros_i = IDX_W'(zl);
        @(posedge clk); #1;
        blk_start_i = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy_o, 1);
        chk("err_after_start", err_o, (tc + zl > MAX_COEFF) ? 1 : 0);
        @(posedge clk); #1;
        n = (tc > MAX_COEFF) ? MAX_COEFF : tc;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                pair_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            pair_valid_i = 1'b1;
            level_i = COEFF_W'(lev_a[k]);
            run_before_i = IDX_W'(run_a[k]);
            t = 0;
            forever begin
                @(negedge clk);
                if (pair_ready_o) break;
                t++;
                if (t > 50) begin
                    chk("pair_ready_timeout", 0, 1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        pair_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == blk_d0 && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 600) chk("blk_done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - blk_d0, 1);
        chk("queue_drained", exp_val_q.size(), 0);
        chk("idle_after_block", busy_o, 0);
    endtask

    task automatic run_block(input int tc, input int zl, input int gap_max);
        model(tc, zl);
        push_expect();
        start_block(tc, zl, gap_max);
        wait_done();
    endtask

    task automatic rand_pairs(input int zl);
        int rem, r, lv;
        rem = zl;
        for (int k = 0; k < 16; k++) begin
            lv = int'($urandom_range(0, 255)) - 128;
            if (lv == 0) lv = 1;
            lev_a[k] = lv;
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, rem));
            run_a[k] = r;
            rem -= (r > rem) ? rem : r;
        end
    endtask

    // Downstream ready: optional random backpressure plus a targeted stall.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_n > 0 && coeff_valid_o && int'(coeff_idx_o) == stall_idx) begin
                coeff_ready_i = 1'b0;
                stall_n--;
            end else if (rdy_rand) begin
                coeff_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                coeff_ready_i = 1'b1;
            end
        end
    end

    initial begin
        bit hold_pending;
        int prev_c, prev_i, v, i;
        hold_pending = 1'b0;
        prev_c = 0;
        prev_i = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hold_pending) begin
                    chk("hold_valid", coeff_valid_o, 1);
                    chk("hold_coeff", int'($signed(coeff_o)), prev_c);
                    chk("hold_idx", int'(coeff_idx_o), prev_i);
                end
                hold_pending = coeff_valid_o && !coeff_ready_i;
                prev_c = int'($signed(coeff_o));
                prev_i = int'(coeff_idx_o);
                if (coeff_valid_o && coeff_ready_i) begin
                    if (exp_val_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        v = exp_val_q.pop_front();
                        i = exp_idx_q.pop_front();
                        chk("coeff", int'($signed(coeff_o)), v);
                        chk("coeff_idx", int'(coeff_idx_o), i);
                    end
                end
                if (blk_done_o) begin
                    done_cnt++;
                    if (exp_err_q.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("err_at_done", int'(err_o), int'(exp_err_q.pop_front()));
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        int tc, zl, t;
        int ref2[16] = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        #12;
        chk("rst_valid", coeff_valid_o, 0);
        chk("rst_coeff", int'(coeff_o), 0);
        chk("rst_idx", int'(coeff_idx_o), 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", blk_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_pair_ready", pair_ready_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Empty block: FILL skipped, sixteen zeros.
        run_block(0, 0, 0);

        // Worked example with hand-derived output order.
        lev_a[0:4] = '{1, 1, -1, -1, 3};
        run_a[0:4] = '{1, 0, 2, 0, 5};
        for (int k = 0; k < 16; k++) exp_blk[k] = ref2[k];
        exp_err = 1'b0;
        push_expect();
        start_block(5, 4, 0);
        wait_done();

        // Same block, gapped pairs and a three-cycle stall at index 4.
        stall_idx = 4;
        stall_n = 3;
        for (int k = 0; k < 16; k++) exp_blk[k] = ref2[k];
        exp_err = 1'b0;
        push_expect();
        start_block(5, 4, 3);
        wait_done();
        chk("stall_consumed", stall_n, 0);
        stall_idx = -1;

        // Header error: tc+zl exceeds the block.
        rand_pairs(8);
        run_block(10, 8, 1);
        rand_pairs(0);
        run_block(2, 0, 0);

        // Full block, levels 16..1 land at indices 15..0.
        for (int k = 0; k < 16; k++) begin
            lev_a[k] = 16 - k;
            run_a[k] = 0;
        end
        run_block(16, 0, 0);

        // run_before larger than zeros left.
        lev_a[0:2] = '{5, -6, 7};
        run_a[0:2] = '{2, 0, 0};
        run_block(3, 0, 0);

        // Overlong TotalCoeff.
        rand_pairs(0);
        run_block(20, 0, 0);

        // Randomised blocks with backpressure.
        rdy_rand = 1'b1;
        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 9) == 0) begin
                tc = $urandom_range(0, 20);
                zl = $urandom_range(0, 15);
            end else begin
                tc = $urandom_range(0, 16);
                zl = (tc == 16) ? 0 : int'($urandom_range(0, 16 - tc));
                if (zl > 15) zl = 15;
            end
            rand_pairs(zl);
            run_block(tc, zl, 2);
        end
        rdy_rand = 1'b0;

        // Asynchronous reset while stalled at index 7.
        stall_idx = 7;
        stall_n = 1000;
        rand_pairs(3);
        model(6, 3);
        push_expect();
        start_block(6, 3, 0);
        t = 0;
        forever begin
            @(negedge clk);
            if (coeff_valid_o && coeff_idx_o == IDX_W'(7)) break;
            t++;
            if (t > 100) begin
                chk("reach_idx7_timeout", 0, 1);
                break;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", coeff_valid_o, 0);
        chk("mid_rst_coeff", int'(coeff_o), 0);
        chk("mid_rst_idx", int'(coeff_idx_o), 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", blk_done_o, 0);
        chk("mid_rst_err", err_o, 0);
        exp_val_q.delete();
        exp_idx_q.delete();
        exp_err_q.delete();
        stall_n = 0;
        stall_idx = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy_o, 0);
        lev_a[0:1] = '{-9, 4};
        run_a[0:1] = '{1, 0};
        run_block(2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
